// File: rtl/ps2_key_scheduler.sv
// PS/2 scancode sequencer that turns make/break/extended streams into per-player button vectors.
// Optional feature macro: KEY_ARROW_EN (extended arrows and keypad enter drive player 2).
module ps2_key_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_err,
    output logic [4:0] player1_btns,
    output logic [4:0] player2_btns,
    output logic       prefix_busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       held1_q, held1_d, held2_q, held2_d;
    logic [3:0]       dir1_q, dir1_d, dir2_q, dir2_d;
    logic [4:0]       p1_btns_q, p1_btns_d, p2_btns_q, p2_btns_d;
    logic             busy_q, busy_d;

    logic             evt_valid, evt_make, evt_ext, evt_clr;
    logic [4:0]       key_res;

    // Returns {hit, is_player2, bit index}; index 0..3 = up/down/left/right, 4 = fire.
    function automatic logic [4:0] key_lookup(input logic [7:0] code, input logic ext);
        logic [4:0] r;
        r = '0;
        if (!ext) begin
            case (code)
                8'h1D: r = {2'b10, 3'd0};
                8'h1B: r = {2'b10, 3'd1};
                8'h1C: r = {2'b10, 3'd2};
                8'h23: r = {2'b10, 3'd3};
                8'h29: r = {2'b10, 3'd4};
                8'h43: r = {2'b11, 3'd0};
                8'h42: r = {2'b11, 3'd1};
                8'h3B: r = {2'b11, 3'd2};
                8'h4B: r = {2'b11, 3'd3};
                8'h5A: r = {2'b11, 3'd4};
                default: r = '0;
            endcase
        end
`ifdef KEY_ARROW_EN
        else begin
            case (code)
                8'h75: r = {2'b11, 3'd0};
                8'h72: r = {2'b11, 3'd1};
                8'h6B: r = {2'b11, 3'd2};
                8'h74: r = {2'b11, 3'd3};
                8'h5A: r = {2'b11, 3'd4};
                default: r = '0;
            endcase
        end
`endif
        return r;
    endfunction

    // Applies one make/break to a player's held mask and current direction; returns {held, dir}.
    function automatic logic [8:0] key_update(input logic [4:0] held, input logic [3:0] dir,
                                              input logic is_make, input logic [2:0] idx);
        logic [4:0] h;
        logic [3:0] d;
        logic [4:0] bitm;
        h    = held;
        d    = dir;
        bitm = 5'(5'd1 << idx);
        if (is_make) begin
            if ((held & bitm) == 5'd0) begin
                h = held | bitm;
                if (idx != 3'd4) d = bitm[3:0];
            end
        end else begin
            h = held & ~bitm;
            if ((dir & bitm[3:0]) != 4'd0) begin
                if (h[0])      d = 4'b0001;
                else if (h[1]) d = 4'b0010;
                else if (h[2]) d = 4'b0100;
                else if (h[3]) d = 4'b1000;
                else           d = 4'b0000;
            end
        end
        return {h, d};
    endfunction

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            held1_q   <= '0;
            held2_q   <= '0;
            dir1_q    <= '0;
            dir2_q    <= '0;
            p1_btns_q <= '0;
            p2_btns_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            held1_q   <= held1_d;
            held2_q   <= held2_d;
            dir1_q    <= dir1_d;
            dir2_q    <= dir2_d;
            p1_btns_q <= p1_btns_d;
            p2_btns_q <= p2_btns_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        held1_d   = held1_q;
        held2_d   = held2_q;
        dir1_d    = dir1_q;
        dir2_d    = dir2_q;
        evt_valid = 1'b0;
        evt_make  = 1'b0;
        evt_ext   = 1'b0;
        evt_clr   = 1'b0;

        // Prefix sequencing; a received byte always takes precedence over the timeout.
        if (byte_valid) begin
            cnt_d = '0;
            if (byte_err) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (byte_data == 8'hE0)      state_d = ST_EXT;
                        else if (byte_data == 8'hF0) state_d = ST_BRK;
                        else if (byte_data == 8'hAA) evt_clr = 1'b1;
                        else begin
                            evt_valid = 1'b1;
                            evt_make  = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (byte_data == 8'hF0) begin
                            state_d = ST_EXT_BRK;
                        end else begin
                            evt_valid = 1'b1;
                            evt_make  = 1'b1;
                            evt_ext   = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        if (byte_data != 8'hF0) begin
                            evt_valid = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                    default: begin
                        evt_valid = 1'b1;
                        evt_ext   = 1'b1;
                        state_d   = ST_IDLE;
                    end
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        key_res = key_lookup(byte_data, evt_ext);
        if (evt_clr) begin
            held1_d = '0;
            held2_d = '0;
            dir1_d  = '0;
            dir2_d  = '0;
        end else if (evt_valid && key_res[4]) begin
            if (key_res[3]) {held2_d, dir2_d} = key_update(held2_q, dir2_q, evt_make, key_res[2:0]);
            else            {held1_d, dir1_d} = key_update(held1_q, dir1_q, evt_make, key_res[2:0]);
        end

        p1_btns_d = {held1_d[4], dir1_d};
        p2_btns_d = {held2_d[4], dir2_d};
        busy_d    = (state_d != ST_IDLE);
    end

    assign player1_btns = p1_btns_q;
    assign player2_btns = p2_btns_q;
    assign prefix_busy  = busy_q;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Randomized bench for ps2_key_scheduler against a press/release reference model.
module tb_ps2_key_scheduler;

    localparam int unsigned T = 16;

    logic       clk_50m = 1'b0;
    logic       rst_n = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_err = 1'b0;
    logic [4:0] player1_btns, player2_btns;
    logic       prefix_busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending prefix flags, held keys and current direction per player.
    bit m_ext, m_brk;
    int m_idle;
    bit m_held [2][5];
    int m_cur [2];

    byte unsigned p1_codes [5] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29};
    byte unsigned p2_codes [5] = '{8'h43, 8'h42, 8'h3B, 8'h4B, 8'h5A};
    byte unsigned ar_codes [5] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};

    ps2_key_scheduler #(.TIMEOUT_CYCLES(T)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_err(byte_err), .player1_btns(player1_btns), .player2_btns(player2_btns),
        .prefix_busy(prefix_busy)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_idle = 0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 5; k++) m_held[p][k] = 0;
            m_cur[p] = -1;
        end
    endfunction

    function automatic logic [4:0] model_btns(input int p);
        logic [4:0] r;
        r = '0;
        r[4] = m_held[p][4];
        if (m_cur[p] >= 0) r[m_cur[p]] = 1'b1;
        return r;
    endfunction

    function automatic void model_key(input byte unsigned code, input bit ext, input bit make);
        int p, k;
        p = -1; k = -1;
        for (int i = 0; i < 5; i++) begin
            if (!ext && code == p1_codes[i]) begin p = 0; k = i; end
            if (!ext && code == p2_codes[i]) begin p = 1; k = i; end
`ifdef KEY_ARROW_EN
            if (ext && code == ar_codes[i]) begin p = 1; k = i; end
`endif
        end
        if (p < 0) return;
        if (make) begin
            if (!m_held[p][k]) begin
                m_held[p][k] = 1;
                if (k < 4) m_cur[p] = k;
            end
        end else begin
            m_held[p][k] = 0;
            if (m_cur[p] == k) begin
                m_cur[p] = -1;
                for (int d = 3; d >= 0; d--) if (m_held[p][d]) m_cur[p] = d;
            end
        end
    endfunction

    function automatic void model_step(input bit valid, input byte unsigned b, input bit err);
        if (valid) begin
            m_idle = 0;
            if (err) begin
                m_ext = 0; m_brk = 0;
            end else if (!m_ext && !m_brk) begin
                if (b == 8'hE0) m_ext = 1;
                else if (b == 8'hF0) m_brk = 1;
                else if (b == 8'hAA) begin
                    for (int p = 0; p < 2; p++) begin
                        for (int k = 0; k < 5; k++) m_held[p][k] = 0;
                        m_cur[p] = -1;
                    end
                end else model_key(b, 0, 1);
            end else if (m_ext && !m_brk) begin
                if (b == 8'hF0) m_brk = 1;
                else begin model_key(b, 1, 1); m_ext = 0; end
            end else if (!m_ext) begin
                if (b != 8'hF0) begin model_key(b, 0, 0); m_brk = 0; end
            end else begin
                model_key(b, 1, 0); m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle == int'(T)) begin m_ext = 0; m_brk = 0; m_idle = 0; end
        end
    endfunction

    task automatic check_all();
        check_val("p1", 8'(player1_btns), 8'(model_btns(0)));
        check_val("p2", 8'(player2_btns), 8'(model_btns(1)));
        check_val("busy", 8'(prefix_busy), 8'(m_ext | m_brk));
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        byte_valid = 1'b1; byte_data = b; byte_err = err;
        @(posedge clk_50m); #1;
        byte_valid = 1'b0; byte_err = 1'b0;
        model_step(1, b, err);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_50m); #1;
            model_step(0, 8'h00, 0);
            check_all();
        end
    endtask

    initial begin
        byte unsigned pool [26];
        int r;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            pool[i] = p1_codes[i]; pool[5+i] = p2_codes[i]; pool[10+i] = ar_codes[i];
        end
        pool[15] = 8'hE0; pool[16] = 8'hE0; pool[17] = 8'hF0; pool[18] = 8'hF0;
        pool[19] = 8'hF0; pool[20] = 8'hAA; pool[21] = 8'h00; pool[22] = 8'hFF;
        pool[23] = 8'h1D; pool[24] = 8'h43; pool[25] = 8'h23;

        repeat (3) @(posedge clk_50m);
        #1 rst_n = 1'b1;
        check_all();

        send(8'h1D, 0);
        check_val("tp_make_up", 8'(player1_btns), 8'b00001);
        send(8'hF0, 0);
        check_val("tp_busy_f0", 8'(prefix_busy), 8'd1);
        send(8'h1D, 0);
        check_val("tp_break_up", 8'(player1_btns), 8'b00000);

        send(8'h1D, 0); send(8'h23, 0); send(8'h29, 0);
        check_val("tp_fire_right", 8'(player1_btns), 8'b11000);
        send(8'hF0, 0); send(8'h23, 0);
        check_val("tp_fallback", 8'(player1_btns), 8'b10001);
        send(8'hF0, 0); send(8'h29, 0);
        check_val("tp_fire_rel", 8'(player1_btns), 8'b00001);

        send(8'h43, 0); send(8'h1B, 0);
        repeat (5) begin
            send(8'h43, 0);
            check_val("tp_rep_p2", 8'(player2_btns), 8'b00001);
            check_val("tp_rep_p1", 8'(player1_btns), 8'b00010);
        end
        send(8'hAA, 0);
        check_val("tp_aa_p1", 8'(player1_btns), 8'b00000);
        check_val("tp_aa_p2", 8'(player2_btns), 8'b00000);

        send(8'hF0, 0);
        idle(T + 1);
        check_val("tp_timeout", 8'(prefix_busy), 8'd0);
        send(8'h1C, 0);
        check_val("tp_after_to", 8'(player1_btns), 8'b00100);
        send(8'hF0, 0); send(8'h1C, 1);
        check_val("tp_err_busy", 8'(prefix_busy), 8'd0);
        check_val("tp_err_mask", 8'(player1_btns), 8'b00100);

        send(8'hE0, 0); send(8'h75, 0);
`ifdef KEY_ARROW_EN
        check_val("tp_arrow_make", 8'(player2_btns), 8'b00001);
`else
        check_val("tp_arrow_make", 8'(player2_btns), 8'b00000);
`endif
        send(8'hE0, 0); send(8'hF0, 0);
        check_val("tp_ext_brk_busy", 8'(prefix_busy), 8'd1);
        send(8'h75, 0);
        check_val("tp_arrow_brk", 8'(player2_btns), 8'b00000);
        check_val("tp_arrow_idle", 8'(prefix_busy), 8'd0);

        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6) idle(int'($urandom_range(1, T + 4)));
            else if (r < 12) send(8'($urandom), 1);
            else send(8'(pool[$urandom_range(0, 25)]), 0);
        end

        send(8'h1D, 0); send(8'h43, 0); send(8'hE0, 0); send(8'hF0, 0);
        #3 rst_n = 1'b0;
        #1;
        check_val("rst_p1", 8'(player1_btns), 8'd0);
        check_val("rst_p2", 8'(player2_btns), 8'd0);
        check_val("rst_busy", 8'(prefix_busy), 8'd0);
        model_reset();
        @(posedge clk_50m); #1 rst_n = 1'b1;
        send(8'h5A, 0);
        check_val("rst_then_fire", 8'(player2_btns), 8'b10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
